// File: rtl/snn_pkg.sv
// Shared types and helpers for the SNN front-end.
// Voltage-domain width, saturation ceiling and refractory FSM states.
package snn_pkg;

   localparam int VW = 14;
   localparam logic [VW-1:0] VMAX = 14'h3FFF;

   typedef logic [VW-1:0] volt_t;

   typedef enum logic {
      IDLE,
      REFRAC
   } refrac_state_t;

   function automatic volt_t sat_add(volt_t a, logic [VW:0] b);
      logic [VW+1:0] s;
      s = {2'b00, a} + {1'b0, b};
      if (s > {2'b00, VMAX}) begin
         return VMAX;
      end
      return s[VW-1:0];
   endfunction

endpackage

// File: rtl/psp_trace.sv
// One decaying post-synaptic-potential trace register.
// Decays each cycle, adds the weight on a spike, saturates, clears on demand.
module psp_trace
   import snn_pkg::*;
#(
   parameter int    DECAY_SHIFT = 2,
   parameter volt_t VMAX        = snn_pkg::VMAX
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  i_spike,
   input  volt_t i_weight,
   input  logic  i_clear,
   input  logic  i_hold,
   output volt_t o_trace
);

   localparam volt_t RES = volt_t'(1 << DECAY_SHIFT);

   volt_t trace_q;
   volt_t trace_d;
   volt_t dec;
   volt_t nxt;
   logic [VW:0] add;

   always_comb begin
      dec = trace_q - (trace_q >> DECAY_SHIFT);
      add = i_spike ? {1'b0, i_weight} : '0;
      nxt = sat_add(dec, add);
      if (nxt > VMAX) begin
         nxt = VMAX;
      end
      trace_d = trace_q;
      if (i_clear) begin
         trace_d = '0;
      end else if (!i_hold) begin
         // a small residue would never decay away under the shift rule
         if (!i_spike && (trace_q < RES)) begin
            trace_d = '0;
         end else begin
            trace_d = nxt;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         trace_q <= '0;
      end else begin
         trace_q <= trace_d;
      end
   end

   assign o_trace = trace_q;

endmodule

// File: rtl/psp_decay_accum.sv
// PSP trace bank, saturated trace sum, membrane leak and refractory FSM
// feeding the SRM0 spike/sum stage.
module psp_decay_accum
   import snn_pkg::*;
#(
   parameter int    N_SYN         = 4,
   parameter int    DECAY_SHIFT   = 2,
   parameter int    LEAK_SHIFT    = 4,
   parameter int    REFRAC_CYCLES = 4,
   parameter volt_t VMAX          = snn_pkg::VMAX
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_SYN-1:0]    i_spikes,
   input  logic [VW*N_SYN-1:0] i_weights,
   input  volt_t               i_voltage,
   input  logic                i_post_spike,
   output volt_t               o_sum,
   output volt_t               o_cond_decay,
   output logic                o_refractory
);

   localparam int SW = VW + $clog2(N_SYN);
   localparam int CW = (REFRAC_CYCLES > 1) ? $clog2(REFRAC_CYCLES) : 1;

   refrac_state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   volt_t         sum_q, sum_d;
   volt_t         cd_q, cd_d;

   volt_t         trace [N_SYN];
   logic [SW-1:0] tsum;
   logic          trig;
   logic          hold;

   assign trig = (state_q == IDLE) && i_post_spike;
   assign hold = (state_q == REFRAC);

   for (genvar k = 0; k < N_SYN; k++) begin : g_syn
      psp_trace #(
         .DECAY_SHIFT (DECAY_SHIFT),
         .VMAX        (VMAX)
      ) u_trace (
         .clk      (clk),
         .reset    (reset),
         .i_spike  (i_spikes[k]),
         .i_weight (i_weights[VW*k +: VW]),
         .i_clear  (trig),
         .i_hold   (hold),
         .o_trace  (trace[k])
      );
   end

   always_comb begin
      tsum = '0;
      for (int k = 0; k < N_SYN; k++) begin
         tsum = tsum + SW'(trace[k]);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (i_post_spike) begin
               state_d = REFRAC;
               cnt_d   = CW'(REFRAC_CYCLES - 1);
            end
         end
         REFRAC: begin
            // a second post-spike here does not restart the period
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      sum_d = '0;
      cd_d  = '0;
      if (!trig && !hold) begin
         if (tsum > SW'(VMAX)) begin
            sum_d = VMAX;
         end else begin
            sum_d = tsum[VW-1:0];
         end
         cd_d = i_voltage - (i_voltage >> LEAK_SHIFT);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sum_q   <= '0;
         cd_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cd_q    <= cd_d;
      end
   end

   assign o_sum        = sum_q;
   assign o_cond_decay = cd_q;
   assign o_refractory = (state_q == REFRAC);

endmodule

// File: tb/tb_psp_decay_accum.sv
// Bench for psp_decay_accum: directed scenarios plus random traffic
// against a cycle-level arithmetic model of the trace bank and FSM.
module tb_psp_decay_accum;

   localparam int N  = 4;
   localparam int DS = 2;
   localparam int LS = 4;
   localparam int RC = 4;
   localparam int VM = 16'h3FFF;

   logic            clk;
   logic            reset;
   logic [N-1:0]    i_spikes;
   logic [14*N-1:0] i_weights;
   logic [13:0]     i_voltage;
   logic            i_post_spike;
   logic [13:0]     o_sum;
   logic [13:0]     o_cond_decay;
   logic            o_refractory;

   int total = 0;
   int bad   = 0;

   int m_tr [N];
   int m_sum;
   int m_cd;
   int m_refr;

   psp_decay_accum #(
      .N_SYN         (N),
      .DECAY_SHIFT   (DS),
      .LEAK_SHIFT    (LS),
      .REFRAC_CYCLES (RC),
      .VMAX          (14'h3FFF)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .i_spikes     (i_spikes),
      .i_weights    (i_weights),
      .i_voltage    (i_voltage),
      .i_post_spike (i_post_spike),
      .o_sum        (o_sum),
      .o_cond_decay (o_cond_decay),
      .o_refractory (o_refractory)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic model_reset();
      for (int k = 0; k < N; k++) m_tr[k] = 0;
      m_sum  = 0;
      m_cd   = 0;
      m_refr = 0;
   endtask

   // remaining refractory edges; outputs are zero while any remain
   task automatic model_edge();
      int s;
      int t;
      int w;
      if (m_refr > 0) begin
         m_refr = m_refr - 1;
         m_sum  = 0;
         m_cd   = 0;
      end else if (i_post_spike) begin
         for (int k = 0; k < N; k++) m_tr[k] = 0;
         m_sum  = 0;
         m_cd   = 0;
         m_refr = RC;
      end else begin
         s = 0;
         for (int k = 0; k < N; k++) s = s + m_tr[k];
         m_sum = (s > VM) ? VM : s;
         m_cd  = int'(i_voltage) - int'(i_voltage) / (1 << LS);
         for (int k = 0; k < N; k++) begin
            t = m_tr[k];
            w = int'(i_weights[14*k +: 14]);
            if (!i_spikes[k] && t < (1 << DS)) begin
               t = 0;
            end else begin
               t = t - t / (1 << DS) + (i_spikes[k] ? w : 0);
               if (t > VM) t = VM;
            end
            m_tr[k] = t;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic set_w(input int k, input int v);
      i_weights[14*k +: 14] = 14'(v);
   endtask

   task automatic test_reset();
      reset        = 0;
      i_spikes     = '0;
      i_weights    = '0;
      i_voltage    = '0;
      i_post_spike = 0;
      model_reset();
      #12;
      total++;
      if (o_sum !== 14'h0) begin
         bad++;
         $display("FAIL reset_sum got=%h want=0", o_sum);
      end
      total++;
      if (o_cond_decay !== 14'h0) begin
         bad++;
         $display("FAIL reset_cd got=%h want=0", o_cond_decay);
      end
      total++;
      if (o_refractory !== 1'b0) begin
         bad++;
         $display("FAIL reset_refr got=%b want=0", o_refractory);
      end
      @(negedge clk);
      reset = 1;
      step();
   endtask

   task automatic test_single_decay();
      int exp_v [3] = '{14'h0400, 14'h0300, 14'h0240};
      int prev;
      bit zero;
      set_w(0, 14'h0400);
      i_spikes = 4'b0001;
      step();
      i_spikes = '0;
      step();
      for (int i = 0; i < 3; i++) begin
         total++;
         if (o_sum !== 14'(exp_v[i])) begin
            bad++;
            $display("FAIL decay_%0d got=%h want=%h", i, o_sum, 14'(exp_v[i]));
         end
         step();
      end
      prev = int'(o_sum);
      zero = 0;
      for (int i = 0; i < 60 && !zero; i++) begin
         total++;
         if (int'(o_sum) > prev || o_sum !== 14'(m_sum)) begin
            bad++;
            $display("FAIL decay_mono got=%h want=%h prev=%h",
                     o_sum, 14'(m_sum), 14'(prev));
         end
         prev = int'(o_sum);
         if (o_sum == 14'h0) zero = 1;
         else step();
      end
      total++;
      if (!zero) begin
         bad++;
         $display("FAIL decay_to_zero got=%h want=0", o_sum);
      end
   endtask

   task automatic test_leak();
      int vin  [3] = '{14'h1000, 14'h000F, 0};
      int vexp [3] = '{14'h0F00, 14'h000F, 0};
      for (int i = 0; i < 3; i++) begin
         i_voltage = 14'(vin[i]);
         step();
         total++;
         if (o_cond_decay !== 14'(vexp[i])) begin
            bad++;
            $display("FAIL leak_%0d got=%h want=%h",
                     i, o_cond_decay, 14'(vexp[i]));
         end
      end
   endtask

   task automatic test_saturation();
      for (int k = 0; k < N; k++) set_w(k, 14'h3000);
      i_spikes = 4'b1111;
      step();
      step();
      i_spikes = '0;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (o_sum !== 14'h3FFF || o_sum !== 14'(m_sum)) begin
            bad++;
            $display("FAIL sat_%0d got=%h want=3fff model=%h",
                     i, o_sum, 14'(m_sum));
         end
      end
      for (int k = 0; k < N; k++) begin
         total++;
         if (dut.g_syn[0].u_trace.o_trace !== 14'(m_tr[0]) && k == 0) begin
            bad++;
            $display("FAIL sat_trace got=%h want=%h",
                     dut.g_syn[0].u_trace.o_trace, 14'(m_tr[0]));
         end
      end
   endtask

   task automatic test_refrac(input bit retrig);
      i_voltage = 14'h0800;
      set_w(1, 14'h0123);
      i_spikes = 4'b0010;
      step();
      step();
      i_spikes = '0;
      i_post_spike = 1;
      step();
      i_post_spike = 0;
      for (int j = 0; j < RC; j++) begin
         total++;
         if (o_refractory !== 1'b1 || o_sum !== 14'h0 ||
             o_cond_decay !== 14'h0) begin
            bad++;
            $display("FAIL refrac_k%0d r=%b s=%h cd=%h want=1/0/0",
                     j, o_refractory, o_sum, o_cond_decay);
         end
         i_spikes = 4'($urandom);
         i_post_spike = retrig && (j == 1);
         step();
      end
      i_post_spike = 0;
      total++;
      if (o_refractory !== 1'b0 || o_sum !== 14'h0) begin
         bad++;
         $display("FAIL refrac_exit r=%b s=%h want=0/0",
                  o_refractory, o_sum);
      end
      i_spikes = 4'b0010;
      step();
      i_spikes = '0;
      step();
      total++;
      if (o_sum !== 14'h0123) begin
         bad++;
         $display("FAIL refrac_resume got=%h want=0123", o_sum);
      end
   endtask

   task automatic test_async_reset();
      set_w(2, 14'h0200);
      i_spikes = 4'b0100;
      step();
      i_spikes = '0;
      i_post_spike = 1;
      step();
      i_post_spike = 0;
      step();
      i_voltage = 14'h0400;
      #2;
      reset = 0;
      model_reset();
      #1;
      total++;
      if (o_refractory !== 1'b0 || o_sum !== 14'h0 ||
          o_cond_decay !== 14'h0) begin
         bad++;
         $display("FAIL async_reset r=%b s=%h cd=%h want=0/0/0",
                  o_refractory, o_sum, o_cond_decay);
      end
      @(negedge clk);
      reset = 1;
      i_spikes = 4'b0100;
      step();
      i_spikes = '0;
      step();
      total++;
      if (o_sum !== 14'h0200 || o_cond_decay !== 14'(m_cd)) begin
         bad++;
         $display("FAIL async_resume s=%h cd=%h want=0200/%h",
                  o_sum, o_cond_decay, 14'(m_cd));
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         i_spikes = 4'($urandom);
         if ($urandom_range(0, 7) == 0) begin
            for (int k = 0; k < N; k++) set_w(k, $urandom_range(0, 16'h3FFF));
         end
         i_voltage = 14'($urandom);
         i_post_spike = ($urandom_range(0, 29) == 0);
         step();
         total++;
         if (o_sum !== 14'(m_sum) || o_cond_decay !== 14'(m_cd) ||
             o_refractory !== (m_refr > 0)) begin
            bad++;
            $display("FAIL rand_%0d s=%h cd=%h r=%b want=%h/%h/%b",
                     i, o_sum, o_cond_decay, o_refractory,
                     14'(m_sum), 14'(m_cd), m_refr > 0);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_decay();
      test_leak();
      test_saturation();
      for (int i = 0; i < 8; i++) step();
      test_refrac(1'b0);
      for (int i = 0; i < 8; i++) step();
      test_refrac(1'b1);
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
